hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard and sequencing controller for the 4-register-stage (IF/ID, ID/EX, EX/MEM, MEM/WB) 8-bit datapath with 19-bit instructions and 12-bit PC. It gates PC and IF/ID writes and inserts bubbles for load-use hazards and redirects. It drives EX-stage forwarding selects, drains and halts the pipeline on stack overflow or an external halt request, and keeps saturating stall and flush counters.

## Interface
- CNT_W, 16, width of the performance counters
- DRAIN_CYCLES, 3, cycles of bubble injection before HALT (in-flight depth)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  3 each  source register fields of the IF/ID instruction (bits 10:8, 7:5)
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads that source
- id_redirect  in  1  jump or return decided in ID (pc_src 01/10)
- ex_rs, ex_rt  in  3 each  source fields held in ID/EX
- ex_rd  in  3  destination in ID/EX (bits 13:11)
- ex_reg_write, ex_mem_read  in  1 each  ID/EX control bits
- mem_rd  in  3  destination in EX/MEM
- mem_reg_write  in  1  EX/MEM write-back enable
- wb_rd  in  3  destination in MEM/WB
- wb_reg_write  in  1  MEM/WB write-back enable
- mem_redirect  in  1  taken branch resolved in MEM stage
- stack_overflow  in  1  stack overflow from the stack block
- halt_req  in  1  external halt request, level
- resume  in  1  leave HALT, single-cycle pulse
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID enable
- ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble (all-zero control) into that register
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM ALU result, 01 MEM/WB write data
- halted  out  1  FSM in HALT
- stall_count, flush_count  out  CNT_W each  saturating event counters

## Operation
- FSM states: RUN, DRAIN, HALT. Reset → RUN.
- RUN → DRAIN when stack_overflow or halt_req is sampled high; drain counter loads DRAIN_CYCLES.
- DRAIN: counter decrements each cycle; at 1 → HALT. stack_overflow/halt_req are ignored while in DRAIN.
- HALT → RUN on resume. A resume outside HALT is ignored. HALT persists regardless of halt_req level.
- Forwarding (combinational, all states):
  - fwd_a = 10 if mem_reg_write && mem_rd==ex_rs.
  - Otherwise fwd_a = 01 if wb_reg_write && wb_rd==ex_rs.
  - Otherwise fwd_a = 00.
  - fwd_b is the same using ex_rt. EX/MEM wins over MEM/WB.
- Load-use = ex_mem_read && ex_reg_write && ((id_uses_rs && ex_rd==id_rs) || (id_uses_rt && ex_rd==id_rt)).
- RUN output priority, highest first:
  - mem_redirect: pc_write=1, ifid_flush=idex_flush=exmem_flush=1, ifid_write=1. Overrides load-use and id_redirect.
  - load-use: pc_write=0, ifid_write=0, idex_flush=1.
  - id_redirect: pc_write=1, ifid_flush=1.
  - none: pc_write=1, ifid_write=1, all flushes 0.
- DRAIN: pc_write=0, ifid_write=1, ifid_flush=1, so only bubbles enter.
  - Exception: mem_redirect still asserts pc_write=1, idex_flush=1 and exmem_flush=1, so that resume starts at the correct target.
  - Load-use and id_redirect are ignored.
- HALT: pc_write=0, ifid_write=0, ifid_flush=idex_flush=exmem_flush=1.
- stall_count increments on each load-use stall cycle. flush_count increments on each mem_redirect or id_redirect cycle in RUN, and on each mem_redirect cycle in DRAIN. Both saturate at all-ones and do not wrap.

## Timing
- While rst is low: state=RUN, counters=0, halted=0, pc_write=0, ifid_write=0, all flushes=1, fwd_a=fwd_b=00. Outputs assume run values combinationally after release.
- All control outputs except halted and the counters are combinational from inputs and state, with zero latency. Enables and flushes take effect at the next rising edge of the datapath registers.
- halted is registered: it rises DRAIN_CYCLES edges after the triggering edge in RUN.
- Load-use costs exactly one bubble. The stall deasserts next cycle because the load has moved to EX/MEM.
- A reset asserted mid-DRAIN or mid-HALT returns the FSM to RUN immediately and asynchronously.

## Test plan
- Forwarding:
  - Stimulus: ex_rs=3, mem_rd=3, mem_reg_write=1, wb_rd=3, wb_reg_write=1.
  - Required: fwd_a=10. Dropping mem_reg_write gives fwd_a=01.
- Load-use stall:
  - Stimulus: ex_mem_read=1, ex_reg_write=1, ex_rd=2, id_rs=2, id_uses_rs=1 for one cycle.
  - Required: pc_write=0, ifid_write=0, idex_flush=1 that cycle; stall_count 0→1.
- Load-use, unused source:
  - Stimulus: same as above with id_uses_rs=0.
  - Required: no stall.
- Priority:
  - Stimulus: mem_redirect=1 with load-use and id_redirect both active.
  - Required: pc_write=1, all three flushes=1, flush_count +1, stall_count unchanged.
- Overflow drain and resume:
  - Stimulus: stack_overflow pulse in RUN.
  - Required: 3 DRAIN cycles with pc_write=0 and ifid_flush=1; halted=1 after the 3rd edge; then a resume pulse gives halted=0 and pc_write=1 the following cycle.
- Reset and counter saturation:
  - Stimulus: assert rst low mid-DRAIN.
  - Required: RUN with counters 0 immediately.
  - Stimulus: preload with CNT_W=4, then 20 stall cycles.
  - Required: stall_count holds at 15.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard and sequencing controller: stalls, bubbles,
// EX forwarding selects, drain/halt FSM and saturating event counters.
module hazard_controller #(
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       id_rs,
   input  logic [2:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_redirect,
   input  logic [2:0]       ex_rs,
   input  logic [2:0]       ex_rt,
   input  logic [2:0]       ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [2:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic [2:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic             mem_redirect,
   input  logic             stack_overflow,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [DW-1:0] drain_cnt, drain_cnt_n;
   logic          load_use;
   logic          rs_hit, rt_hit;
   logic          stall_ev, flush_ev;
   logic [1:0]    fwd_a_raw, fwd_b_raw;

   // EX/MEM result is younger than MEM/WB, so it wins
   function automatic logic [1:0] fwd_sel(
      input logic [2:0] src,
      input logic [2:0] m_rd,
      input logic       m_we,
      input logic [2:0] w_rd,
      input logic       w_we
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (m_we && (m_rd == src))
         sel = 2'b10;
      else if (w_we && (w_rd == src))
         sel = 2'b01;
      return sel;
   endfunction

   assign fwd_a_raw = fwd_sel(ex_rs, mem_rd, mem_reg_write,
                              wb_rd, wb_reg_write);
   assign fwd_b_raw = fwd_sel(ex_rt, mem_rd, mem_reg_write,
                              wb_rd, wb_reg_write);

   assign rs_hit   = id_uses_rs && (ex_rd == id_rs);
   assign rt_hit   = id_uses_rt && (ex_rd == id_rt);
   assign load_use = ex_mem_read && ex_reg_write && (rs_hit || rt_hit);

   // Control outputs and counter events
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      fwd_a       = fwd_a_raw;
      fwd_b       = fwd_b_raw;
      stall_ev    = 1'b0;
      flush_ev    = 1'b0;
      unique case (state)
         RUN: begin
            if (mem_redirect) begin
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               flush_ev    = 1'b1;
            end else if (load_use) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_flush = 1'b1;
               stall_ev   = 1'b1;
            end else if (id_redirect) begin
               ifid_flush = 1'b1;
               flush_ev   = 1'b1;
            end
         end
         DRAIN: begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            // a late branch must still land so resume fetches the target
            if (mem_redirect) begin
               pc_write    = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               flush_ev    = 1'b1;
            end
         end
         HALT: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end
         default: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end
      endcase
      if (!rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         fwd_a       = 2'b00;
         fwd_b       = 2'b00;
         stall_ev    = 1'b0;
         flush_ev    = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_n     = state;
      drain_cnt_n = drain_cnt;
      unique case (state)
         RUN: begin
            if (stack_overflow || halt_req) begin
               state_n     = DRAIN;
               drain_cnt_n = DRAIN_LOAD;
            end
         end
         DRAIN: begin
            if (drain_cnt <= DW'(1)) begin
               state_n     = HALT;
               drain_cnt_n = '0;
            end else begin
               drain_cnt_n = drain_cnt - DW'(1);
            end
         end
         HALT: begin
            if (resume)
               state_n = RUN;
         end
         default: begin
            state_n     = RUN;
            drain_cnt_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         drain_cnt <= '0;
         halted    <= 1'b0;
      end else begin
         state     <= state_n;
         drain_cnt <= drain_cnt_n;
         halted    <= (state_n == HALT);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_ev && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
         if (flush_ev && (flush_count != '1))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller: combinational control
// table, drain/halt/resume sequence, async reset and counter saturation.
module tb_hazard_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic        id_uses_rs, id_uses_rt, id_redirect;
   logic        ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
   logic        mem_redirect, stack_overflow, halt_req, resume;
   logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
   logic [1:0]  fwd_a, fwd_b;
   logic        halted;
   logic [15:0] stall_count, flush_count;

   logic        pc_write4, ifid_write4, ifid_flush4;
   logic        idex_flush4, exmem_flush4, halted4;
   logic [1:0]  fwd_a4, fwd_b4;
   logic [3:0]  stall_count4, flush_count4;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hazard_controller #(.CNT_W(16), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_redirect(id_redirect),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .mem_redirect(mem_redirect), .stack_overflow(stack_overflow),
      .halt_req(halt_req), .resume(resume),
      .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   hazard_controller #(.CNT_W(4), .DRAIN_CYCLES(3)) dut4 (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_redirect(id_redirect),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .mem_redirect(mem_redirect), .stack_overflow(stack_overflow),
      .halt_req(halt_req), .resume(resume),
      .pc_write(pc_write4), .ifid_write(ifid_write4),
      .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
      .exmem_flush(exmem_flush4),
      .fwd_a(fwd_a4), .fwd_b(fwd_b4), .halted(halted4),
      .stall_count(stall_count4), .flush_count(flush_count4)
   );

   // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}
   typedef struct {
      string      name;
      logic [2:0] id_rs, id_rt;
      logic       uses_rs, uses_rt, id_redir;
      logic [2:0] ex_rs, ex_rt, ex_rd;
      logic       ex_rw, ex_mr;
      logic [2:0] mem_rd;
      logic       mem_rw;
      logic [2:0] wb_rd;
      logic       wb_rw, mem_redir;
      logic [4:0] exp_ctl;
      logic [1:0] exp_a, exp_b;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [4:0] ctl();
      return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush};
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic idle();
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_redirect = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
      ex_reg_write = 0; ex_mem_read = 0; mem_rd = 0;
      mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
      mem_redirect = 0; stack_overflow = 0; halt_req = 0; resume = 0;
   endtask

   task automatic apply(input vec_t v);
      id_rs = v.id_rs; id_rt = v.id_rt;
      id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
      id_redirect = v.id_redir;
      ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_rd = v.ex_rd;
      ex_reg_write = v.ex_rw; ex_mem_read = v.ex_mr;
      mem_rd = v.mem_rd; mem_reg_write = v.mem_rw;
      wb_rd = v.wb_rd; wb_reg_write = v.wb_rw;
      mem_redirect = v.mem_redir;
   endtask

   task automatic set_loaduse();
      ex_mem_read = 1; ex_reg_write = 1; ex_rd = 2;
      id_rs = 2; id_uses_rs = 1;
   endtask

   initial begin
      //            name        irs irt urs urt jr  ers ert erd erw emr mrd mrw wrd wrw mr  ctl       a      b
      vecs[0]  = '{"idle",      0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 5'b11000, 2'b00, 2'b00};
      vecs[1]  = '{"fwd_mem",   0,  0,  0,  0,  0,  3,  5,  0,  0,  0,  3,  1,  3,  1,  0, 5'b11000, 2'b10, 2'b00};
      vecs[2]  = '{"fwd_wb",    0,  0,  0,  0,  0,  3,  5,  0,  0,  0,  3,  0,  3,  1,  0, 5'b11000, 2'b01, 2'b00};
      vecs[3]  = '{"fwd_mix",   0,  0,  0,  0,  0,  1,  4,  0,  0,  0,  4,  1,  1,  1,  0, 5'b11000, 2'b01, 2'b10};
      vecs[4]  = '{"lu_rs",     2,  0,  1,  0,  0,  0,  0,  2,  1,  1,  0,  0,  0,  0,  0, 5'b00010, 2'b00, 2'b00};
      vecs[5]  = '{"lu_unused", 2,  0,  0,  0,  0,  0,  0,  2,  1,  1,  0,  0,  0,  0,  0, 5'b11000, 2'b00, 2'b00};
      vecs[6]  = '{"lu_rt",     0,  2,  0,  1,  0,  0,  0,  2,  1,  1,  0,  0,  0,  0,  0, 5'b00010, 2'b00, 2'b00};
      vecs[7]  = '{"lu_no_rw",  2,  0,  1,  0,  0,  0,  0,  2,  0,  1,  0,  0,  0,  0,  0, 5'b11000, 2'b00, 2'b00};
      vecs[8]  = '{"id_redir",  0,  0,  0,  0,  1,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 5'b11100, 2'b00, 2'b00};
      vecs[9]  = '{"priority",  2,  0,  1,  0,  1,  0,  0,  2,  1,  1,  0,  0,  0,  0,  1, 5'b11111, 2'b00, 2'b00};
      vecs[10] = '{"lu_vs_jmp", 2,  0,  1,  0,  1,  0,  0,  2,  1,  1,  0,  0,  0,  0,  0, 5'b00010, 2'b00, 2'b00};

      idle();
      rst = 0;
      mem_rd = 3; mem_reg_write = 1; ex_rs = 3; ex_rt = 3;
      #12;
      chk("rst_ctl", 32'(ctl()), 32'b00111);
      chk("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_cnt", {stall_count, flush_count}, 0);

      @(negedge clk);
      idle();
      rst = 1;
      #1 chk("release_ctl", 32'(ctl()), 32'b11000);

      // one posedge per vector
      foreach (vecs[i]) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         chk({vecs[i].name, "_ctl"}, 32'(ctl()), 32'(vecs[i].exp_ctl));
         chk({vecs[i].name, "_fa"}, 32'(fwd_a), 32'(vecs[i].exp_a));
         chk({vecs[i].name, "_fb"}, 32'(fwd_b), 32'(vecs[i].exp_b));
         if (i == 4) begin
            @(posedge clk); #1;
            chk("stall_0to1", 32'(stall_count), 1);
         end
      end
      @(negedge clk);
      idle();
      #1;
      chk("table_stalls", 32'(stall_count), 3);
      chk("table_flushes", 32'(flush_count), 2);

      // overflow, drain, halt, resume
      stack_overflow = 1;
      #1 chk("ovf_run_ctl", 32'(ctl()), 32'b11000);
      @(negedge clk);
      stack_overflow = 0;
      for (int c = 1; c <= 3; c++) begin
         if (c == 2) begin
            mem_redirect = 1; set_loaduse(); id_redirect = 1;
            halt_req = 1;
            #1 chk("drain_mredir", 32'(ctl()), 32'b11111);
         end else begin
            #1 chk($sformatf("drain%0d_ctl", c), 32'(ctl()), 32'b01100);
         end
         chk($sformatf("drain%0d_halted", c), 32'(halted), 0);
         @(negedge clk);
         idle();
      end
      #1;
      chk("halted", 32'(halted), 1);
      chk("halt_ctl", 32'(ctl()), 32'b00111);
      chk("drain_flushes", 32'(flush_count), 3);
      chk("drain_stalls", 32'(stall_count), 3);
      @(negedge clk);
      #1 chk("halt_persist", 32'(halted), 1);
      resume = 1;
      @(negedge clk);
      resume = 0;
      #1;
      chk("resume_halted", 32'(halted), 0);
      chk("resume_ctl", 32'(ctl()), 32'b11000);

      // reset mid-drain
      halt_req = 1;
      @(negedge clk);
      halt_req = 0;
      #1 chk("pre_rst_drain", 32'(ctl()), 32'b01100);
      #2 rst = 0;
      #1;
      chk("midrst_cnt", {stall_count, flush_count}, 0);
      chk("midrst_halted", 32'(halted), 0);
      @(negedge clk);
      rst = 1;
      #1 chk("post_rst_run", 32'(ctl()), 32'b11000);
      repeat (4) @(negedge clk);
      #1;
      chk("post_rst_nohalt", 32'(halted), 0);
      chk("post_rst_ctl", 32'(ctl()), 32'b11000);

      // saturation
      set_loaduse();
      repeat (20) @(negedge clk);
      idle();
      #1;
      chk("sat4", 32'(stall_count4), 15);
      chk("wide20", 32'(stall_count), 20);
      @(negedge clk);
      #1 chk("sat4_hold", 32'(stall_count4), 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
